// File: rtl/mlp_pkg.sv
// Constants and FSM encoding shared by the MLP post-processing blocks.
package mlp_pkg;

  localparam int MLP_DATA_W = 8;
  localparam int MLP_ADDR_W = 10;
  localparam int MLP_IDX_W  = 8;

  localparam logic [9:0] MLP_BASE_IN  = 10'h000;
  localparam logic [9:0] MLP_BASE_A   = 10'h100;
  localparam logic [9:0] MLP_BASE_OUT = 10'h200;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } argmax_state_t;

endpackage

// File: rtl/mlp_argmax_cmp.sv
// Combinational signed max / runner-up update for one scanned element.
module argmax_cmp
  import mlp_pkg::*;
#(
  parameter int DATA_W = MLP_DATA_W,
  parameter int IDX_W  = MLP_IDX_W
) (
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] best,
  input  logic [DATA_W-1:0] second,
  input  logic [IDX_W-1:0]  best_idx,
  input  logic [IDX_W-1:0]  i,
  output logic [DATA_W-1:0] best_nxt,
  output logic [DATA_W-1:0] second_nxt,
  output logic [IDX_W-1:0]  best_idx_nxt
);

  // Strict compare keeps the lowest index on ties; a tie still lifts second.
  always_comb begin
    best_nxt     = best;
    second_nxt   = second;
    best_idx_nxt = best_idx;
    if ($signed(x) > $signed(best)) begin
      second_nxt   = best;
      best_nxt     = x;
      best_idx_nxt = i;
    end else if ($signed(x) > $signed(second)) begin
      second_nxt = x;
    end
  end

endmodule

// File: rtl/mlp_argmax.sv
// Scans the output-layer results in data RAM and reports winner, value and margin.
//
// state | meaning
// IDLE  | wait for a rising edge on start
// SCAN  | issue one RAM read address per cycle
// DRAIN | let the read pipeline empty into the compare stage
// FIN   | publish results, pulse done
module mlp_argmax
  import mlp_pkg::*;
#(
  parameter int                DATA_W    = MLP_DATA_W,
  parameter int                ADDR_W    = MLP_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = MLP_BASE_OUT,
  parameter int                IDX_W     = MLP_IDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [IDX_W-1:0]  H,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              busy,
  output logic              done,
  output logic              valid,
  output logic [IDX_W-1:0]  class_idx,
  output logic [DATA_W-1:0] class_val,
  output logic [DATA_W:0]   margin
);

  localparam logic [DATA_W-1:0] VAL_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  argmax_state_t state, state_nxt;

  logic              start_q;
  logic [IDX_W-1:0]  hreg;
  logic [IDX_W-1:0]  iss_cnt;
  logic [IDX_W-1:0]  cmp_idx;
  logic              rd_vld;
  logic [DATA_W-1:0] best, second;
  logic [IDX_W-1:0]  best_idx;
  logic [DATA_W-1:0] best_c, second_c;
  logic [IDX_W-1:0]  best_idx_c;

  logic start_rise, ld_scan, ld_empty, issue, last_cmp, fin;

  assign start_rise = start & ~start_q;

  argmax_cmp #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_cmp (
    .x            (mem_rd_data),
    .best         (best),
    .second       (second),
    .best_idx     (best_idx),
    .i            (cmp_idx),
    .best_nxt     (best_c),
    .second_nxt   (second_c),
    .best_idx_nxt (best_idx_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_rise) state_nxt = (H != '0) ? ST_SCAN : ST_FIN;
      ST_SCAN:  if (iss_cnt == hreg) state_nxt = ST_DRAIN;
      ST_DRAIN: if (last_cmp) state_nxt = ST_FIN;
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ld_scan  = (state == ST_IDLE) && start_rise && (H != '0);
    ld_empty = (state == ST_IDLE) && start_rise && (H == '0);
    issue    = (state == ST_SCAN) && (iss_cnt != hreg);
    last_cmp = rd_vld && (cmp_idx == hreg - IDX_W'(1));
    fin      = (state == ST_FIN);
  end

  // rd_vld marks mem_rd_data holding the element addressed one cycle earlier.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q     <= 1'b0;
      hreg        <= '0;
      iss_cnt     <= '0;
      cmp_idx     <= '0;
      rd_vld      <= 1'b0;
      best        <= '0;
      second      <= '0;
      best_idx    <= '0;
      mem_rd_addr <= BASE_ADDR;
      busy        <= 1'b0;
      done        <= 1'b0;
      valid       <= 1'b0;
      class_idx   <= '0;
      class_val   <= '0;
      margin      <= '0;
    end else begin
      start_q <= start;
      rd_vld  <= (state == ST_SCAN);
      done    <= fin;
      if (ld_scan) begin
        hreg        <= H;
        mem_rd_addr <= BASE_ADDR;
        iss_cnt     <= IDX_W'(1);
        cmp_idx     <= '0;
        busy        <= 1'b1;
        best        <= VAL_MIN;
        second      <= VAL_MIN;
        best_idx    <= '0;
      end
      if (ld_empty) hreg <= '0;
      if (issue) begin
        mem_rd_addr <= mem_rd_addr + ADDR_W'(1);
        iss_cnt     <= iss_cnt + IDX_W'(1);
      end
      if (rd_vld) begin
        best     <= best_c;
        second   <= second_c;
        best_idx <= best_idx_c;
        cmp_idx  <= cmp_idx + IDX_W'(1);
      end
      if (fin) begin
        busy  <= 1'b0;
        valid <= (hreg != '0);
        if (hreg != '0) begin
          class_idx <= best_idx;
          class_val <= best;
          margin    <= {best[DATA_W-1], best} - {second[DATA_W-1], second};
        end
      end
    end
  end

endmodule

// File: tb/tb_mlp_argmax.sv
// Directed-vector bench for mlp_argmax with a behavioural read-port RAM.
module tb_mlp_argmax;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] H = '0;
  logic [9:0] mem_rd_addr;
  logic [7:0] mem_rd_data = '0;
  logic       busy, done, valid;
  logic [7:0] class_idx;
  logic [7:0] class_val;
  logic [8:0] margin;

  logic [7:0] mem [0:1023];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int h;
    int v [4];
    int e_idx;
    int e_val;
    int e_mar;
  } vec_t;

  vec_t tbl [6];

  always #5 clk = ~clk;

  always @(posedge clk) mem_rd_data <= mem[mem_rd_addr];

  mlp_argmax dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .H           (H),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .busy        (busy),
    .done        (done),
    .valid       (valid),
    .class_idx   (class_idx),
    .class_val   (class_val),
    .margin      (margin)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input int h, input int a, input int b, input int c,
                         input int d, input int ei, input int ev, input int em);
    tbl[i].h = h;
    tbl[i].v[0] = a; tbl[i].v[1] = b; tbl[i].v[2] = c; tbl[i].v[3] = d;
    tbl[i].e_idx = ei; tbl[i].e_val = ev; tbl[i].e_mar = em;
  endtask

  // Starts a scan with start held high; returns the edge count (from the start
  // edge = 0) after which done was first seen, or -1 on timeout.
  task automatic run_scan(input int h, output int lat);
    lat = -1;
    @(negedge clk);
    H = 8'(h);
    start = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (n == 0) chk("busy_at_start", int'(busy), (h > 0) ? 1 : 0);
      if (done) begin
        lat = n;
        break;
      end
    end
    @(posedge clk); #1;
    chk("done_one_cycle", int'(done), 0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  // Winner = first index holding the maximum; runner-up = max of all other slots.
  task automatic ref_model(input int n, output int ei, output int ev, output int em);
    int sv, sec;
    ev = -129;
    ei = 0;
    for (int k = 0; k < n; k++) begin
      sv = int'($signed(mem[512 + k]));
      if (sv > ev) begin ev = sv; ei = k; end
    end
    sec = -128;
    for (int k = 0; k < n; k++) begin
      sv = int'($signed(mem[512 + k]));
      if (k != ei && sv > sec) sec = sv;
    end
    em = ev - sec;
  endtask

  initial begin
    int lat, ei, ev, em, dn, hh;

    for (int k = 0; k < 1024; k++) mem[k] = '0;

    set_vec(0, 4,    5,   -3,  17,   9, 2,   17,   8);
    set_vec(1, 3,   40,   40,  -1,   0, 0,   40,   0);
    set_vec(2, 1, -128,    0,   0,   0, 0, -128,   0);
    set_vec(3, 1,  127,    0,   0,   0, 0,  127, 255);
    set_vec(4, 4,   -5,   -2,  -9,  -2, 1,   -2,   0);
    set_vec(5, 4,   -1, -128, 100,  99, 2,  100,   1);

    #12;
    chk("rst_addr",  int'(mem_rd_addr), 32'h200);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_done",  int'(done), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_idx",   int'(class_idx), 0);
    chk("rst_val",   int'(class_val), 0);
    chk("rst_margin", int'(margin), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < tbl[i].h; k++) mem[512 + k] = 8'(tbl[i].v[k]);
      mem[512 + tbl[i].h] = 8'h7f;
      run_scan(tbl[i].h, lat);
      chk($sformatf("v%0d_latency", i), lat, tbl[i].h + 2);
      chk($sformatf("v%0d_idx", i), int'(class_idx), tbl[i].e_idx);
      chk($sformatf("v%0d_val", i), int'($signed(class_val)), tbl[i].e_val);
      chk($sformatf("v%0d_margin", i), int'(margin), tbl[i].e_mar);
      chk($sformatf("v%0d_valid", i), int'(valid), 1);
      chk($sformatf("v%0d_busy_after", i), int'(busy), 0);
    end

    // Empty scan keeps the previous result but clears valid.
    run_scan(0, lat);
    chk("h0_latency", lat, 1);
    chk("h0_valid", int'(valid), 0);
    chk("h0_idx_held", int'(class_idx), 2);
    chk("h0_val_held", int'($signed(class_val)), 100);

    // Start held high, toggled mid-scan, and held past done: exactly one scan.
    hh = 5;
    for (int k = 0; k < hh; k++) mem[512 + k] = 8'(k + 1);
    @(negedge clk);
    H = 8'(hh);
    start = 1'b1;
    dn = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (done) dn++;
      if (n < hh) chk($sformatf("addr_seq%0d", n), int'(mem_rd_addr), 32'h200 + n);
      if (n == hh) chk("addr_hold", int'(mem_rd_addr), 32'h200 + hh - 1);
      if (n == 2) begin @(negedge clk); start = 1'b0; end
      if (n == 3) begin @(negedge clk); start = 1'b1; end
    end
    chk("hold_done_count", dn, 1);
    chk("hold_idx", int'(class_idx), 4);
    chk("hold_margin", int'(margin), 1);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Reset mid-scan of a 26-element run.
    hh = 26;
    for (int k = 0; k < hh; k++) mem[512 + k] = 8'($urandom_range(0, 255));
    @(negedge clk);
    H = 8'(hh);
    start = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_addr", int'(mem_rd_addr), 32'h200);
    chk("abort_valid", int'(valid), 0);
    chk("abort_idx", int'(class_idx), 0);
    dn = 0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done || busy) dn++;
    end
    chk("abort_no_done", dn, 0);

    for (int k = 0; k < hh; k++) mem[512 + k] = 8'($urandom_range(0, 255));
    ref_model(hh, ei, ev, em);
    run_scan(hh, lat);
    chk("r26_latency", lat, hh + 2);
    chk("r26_idx", int'(class_idx), ei);
    chk("r26_val", int'($signed(class_val)), ev);
    chk("r26_margin", int'(margin), em);
    chk("r26_valid", int'(valid), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mlp_argmax.md
Name: mlp_argmax

Overview:
- Post-processing stage downstream of mlp_core.
- After the core's done bit (status bit 0) rises, it scans the H output-layer results in the data RAM output region (base 10'h200) through the RAM's free read port.
- Reports the winning class index, the winning value, and the margin to the runner-up.
- Frees the host from reading all outputs over the bus. Results are exposed in the MLP register map.

Parameters:
- DATA_W, 8, width of signed output activations in data RAM
- ADDR_W, 10, data RAM address width
- BASE_ADDR, 10'h200, address of output neuron 0
- IDX_W, 8, width of neuron count and index

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  level; sampled only in IDLE; a scan begins on its rising edge (registered edge detect)
- H  in  IDX_W  number of output neurons; sampled at scan start
- mem_rd_addr  out  ADDR_W  registered read address to the data RAM read port
- mem_rd_data  in  DATA_W  RAM registered read data, valid one edge after the address edge
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse when results are valid
- valid  out  1  sticky: last scan produced a result (H greater than 0)
- class_idx  out  IDX_W  index of the maximum (lowest index on ties)
- class_val  out  DATA_W  signed maximum value
- margin  out  DATA_W+1  unsigned, class_val minus second-largest value

Behaviour:
- Reset (reset=0, asynchronous) drives all outputs and state to zero:
  - mem_rd_addr=BASE_ADDR, busy=0, done=0, valid=0, class_idx=0, class_val=0, margin=0
  - FSM returns to IDLE
- FSM states: IDLE, SCAN, DRAIN, FIN.
- IDLE:
  - On an edge with start rising and H greater than 0: latch H into hreg, set mem_rd_addr=BASE_ADDR, issue counter=1, busy=1, go to SCAN.
  - Initialise best=-128, second=-128, best_idx=0.
  - If H==0: go to FIN with valid=0; class_idx, class_val and margin are held.
- SCAN:
  - Each edge: mem_rd_addr+1, issue counter+1.
  - When issue counter==hreg, go to DRAIN.
- Read pipeline:
  - Two-stage valid shift register v1, v2. Element i's address is driven after edge i (edges counted from the start edge = 0).
  - The RAM registers mem[BASE+i] at edge i+1. The compare stage consumes it at edge i+2.
- Compare, signed 8-bit:
  - If x > best: second=best, best=x, best_idx=i.
  - Else if x > second: second=x.
  - Equal to best: best is unchanged (lowest index wins). An equal value still updates second.
- DRAIN: wait until v2 has consumed element hreg-1, then go to FIN.
- FIN:
  - Register class_idx=best_idx, class_val=best, margin=best-second (9-bit, sign-extended operands).
  - Set valid=1 if hreg greater than 0, else 0.
  - Pulse done for one cycle, clear busy, return to IDLE.
- Latency: done is high in the cycle after edge hreg+2 relative to the start edge. For H==0: after edge 1.
- H=1: margin=class_val+128.
- Address wrap: BASE_ADDR+H-1 must not exceed 2^ADDR_W-1. Larger H wraps modulo 2^ADDR_W; this is not detected.
- start high while busy: ignored. A new scan needs start low then high again. Holding start high after done does not retrigger.
- Reset mid-scan: immediate abort; outputs return to reset values.
- mem_rd_addr holds its last value in IDLE. The block never writes RAM.

Decomposition:
- Shared package mlp_pkg: DATA_W, ADDR_W, IDX_W, BASE address constants (data_in 10'h000, data_a 10'h100, data_out 10'h200), FSM state encoding.
- One natural sub-module: argmax_cmp, a combinational signed max/second-max update (x, best, second, best_idx, i -> next values). Everything else stays in mlp_argmax.

Test Plan:
- Preload RAM 0x200..0x203 = {5, -3, 17, 9}, H=4, pulse start -> done at edge 6; class_idx=2, class_val=17, margin=8, valid=1.
- Ties: {40, 40, -1}, H=3 -> class_idx=0, class_val=40, margin=0.
- H=1 with value -128 -> class_idx=0, class_val=-128, margin=0. Same test with value 127 -> margin=255.
- H=0 -> done after edge 1, valid=0; prior class_idx and class_val are unchanged.
- Hold start high through done; then toggle start mid-scan -> exactly one scan, one done pulse. Check mem_rd_addr sequence 0x200..0x200+H-1, one address per cycle.
- Assert reset low at edge 3 of an H=26 scan -> busy=0, done never pulses. A fresh scan after release gives the correct result for 26 random signed values, checked against a reference model.
